readout_scheduler: RTL and testbench
====================================

Name: readout_scheduler

Overview:
- Sequences frame readout from the pixel array into the output buffer, one row at a time.
- Per row: selects the row, waits for column lines to settle, and pulses SET_BUFFER into the output buffer. It then waits for the buffer to accept the row and finish shifting it out.
- Sits between the top-level sensor FSM (frame START) and the output buffer. Reports frame completion and handshake timeouts.

Parameters:
- PIXEL_ARRAY_HEIGHT, 4: number of rows read per frame (must be ≥ 2).
- SETTLE_CYCLES, 2: clock cycles ROW_SELECT is held before SET_BUFFER (≥ 1).
- ACK_TIMEOUT, 8: maximum cycles to wait for BUFFER_BUSY to rise after SET_BUFFER (≥ 2).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  level/pulse request to begin a frame; sampled only in IDLE.
- BUFFER_BUSY  input  1  output buffer is shifting data out (its sending state).
- OUTPUT_STALL  input  1  downstream not ready; holds off the next row.
- ROW_SELECT  output  PIXEL_ARRAY_HEIGHT  one-hot row enable to the pixel array.
- ROW_INDEX  output  $clog2(PIXEL_ARRAY_HEIGHT)  binary index of the current row.
- SET_BUFFER  output  1  single-cycle load strobe to the output buffer.
- BUSY  output  1  high in every state except IDLE.
- FRAME_DONE  output  1  single-cycle pulse after the last row drains.
- ERROR  output  1  sticky; set on ACK timeout, cleared by RESET or an accepted START.

Behaviour:
- Reset: synchronous. At a rising CLK edge with RESET=1, state←IDLE, ROW_INDEX←0, settle/timeout counters←0, ERROR←0. Reset applies from any state, including mid-row.
- Reset output values: ROW_SELECT=0, SET_BUFFER=0, BUSY=0, FRAME_DONE=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- States: IDLE, SELECT, LOAD, WAIT_ACK, DRAIN, NEXT.
- IDLE → SELECT:
  - Taken when START=1 is sampled in IDLE.
  - ROW_INDEX←0, ERROR←0, settle counter←0.
  - START in any other state is ignored (not queued).
- SELECT:
  - ROW_SELECT = one-hot(ROW_INDEX).
  - Settle counter increments each cycle.
  - After exactly SETTLE_CYCLES cycles in SELECT, go to LOAD.
- LOAD:
  - Lasts exactly 1 cycle. SET_BUFFER=1, ROW_SELECT held.
  - Timeout counter←0. Go to WAIT_ACK.
- WAIT_ACK:
  - ROW_SELECT held.
  - BUFFER_BUSY=1 → DRAIN.
  - Otherwise the counter increments. Once ACK_TIMEOUT cycles have been spent in WAIT_ACK without BUFFER_BUSY, ERROR←1 and go to IDLE (frame aborted, no FRAME_DONE).
- DRAIN:
  - ROW_SELECT held.
  - Stay while BUFFER_BUSY=1. BUFFER_BUSY=0 → NEXT.
- NEXT:
  - ROW_SELECT=0 (break-before-make between rows).
  - If ROW_INDEX == PIXEL_ARRAY_HEIGHT-1: FRAME_DONE=1 for this single cycle, then IDLE. OUTPUT_STALL is ignored on the last row.
  - Else if OUTPUT_STALL=1: remain in NEXT.
  - Else: ROW_INDEX←ROW_INDEX+1, settle counter←0, go to SELECT.
- Row latency: from START sampled (edge n), ROW_SELECT is valid from edge n and SET_BUFFER is high in cycle n+SETTLE_CYCLES.
- Minimum per-row period = SETTLE_CYCLES + 1 (LOAD) + ≥1 (WAIT_ACK) + drain length + 1 (NEXT).
- ROW_INDEX never wraps within a frame. It is held after frame end until the next START.
- BUFFER_BUSY already high on entry to WAIT_ACK (e.g. from a previous row) still counts as acknowledgement. This is legal because NEXT only advances once BUFFER_BUSY=0 has been observed.
- Counter widths: $clog2 of (parameter+1). No overflow is possible because each counter is compared at its terminal value.

Decomposition:
- Add PIXEL_ARRAY_HEIGHT to the shared PixelSensorConfig package and import it as the default for the parameter.
- Define the state enum typedef readout_state_t in the same package so the top-level FSM and bench can decode it.
- One natural sub-module: reuse the existing Counter component for the settle/timeout count, with reset driven by the state entry. Everything else is a single always_ff FSM plus output decode.

Test Plan:
- Reset mid-DRAIN: assert RESET during row 2 → next cycle ROW_SELECT=0, SET_BUFFER=0, BUSY=0, ROW_INDEX=0, ERROR=0.
- Normal frame (HEIGHT=4, SETTLE=2): START at cycle 0, buffer model raises BUSY 1 cycle after SET_BUFFER for 3 cycles → ROW_SELECT sequence 0001,0010,0100,1000. Exactly 4 SET_BUFFER pulses, each 2 cycles after its row select. One FRAME_DONE after row 3 drains.
- Timeout: buffer model never raises BUFFER_BUSY → ERROR=1 after 8 WAIT_ACK cycles, state IDLE, no FRAME_DONE. A new START clears ERROR.
- Stall: hold OUTPUT_STALL=1 for 5 cycles after row 1 drains → ROW_SELECT=0 for those 5 cycles and ROW_INDEX stays 1. Row 2 select follows 1 cycle after release.
- START while BUSY: pulse START during row 1 → no restart, ROW_INDEX progression unchanged, exactly 4 rows read.
- Stall on last row: OUTPUT_STALL=1 when row 3 drains → FRAME_DONE still pulses immediately, then BUSY=0.

Source files
------------

// File: rtl/readout_scheduler_pkg.sv
// Shared pixel-sensor configuration: array geometry and the readout FSM state encoding,
// visible to both the scheduler RTL and its bench.
package readout_scheduler_pkg;

   localparam int PIXEL_ARRAY_HEIGHT = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SELECT   = 3'd1,
      LOAD     = 3'd2,
      WAIT_ACK = 3'd3,
      DRAIN    = 3'd4,
      NEXT     = 3'd5
   } readout_state_t;

endpackage : readout_scheduler_pkg

// File: rtl/readout_scheduler_counter.sv
// Up-counter with synchronous clear; the scheduler clears it on every state entry so
// its value is the number of cycles already spent in the current state.
module readout_scheduler_counter #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule : readout_scheduler_counter

// File: rtl/readout_scheduler.sv
// Row-by-row frame readout sequencer: select row, settle, strobe the output buffer,
// then wait for it to acknowledge and drain before moving to the next row.
module readout_scheduler #(
   parameter int PIXEL_ARRAY_HEIGHT = readout_scheduler_pkg::PIXEL_ARRAY_HEIGHT,
   parameter int SETTLE_CYCLES      = 2,
   parameter int ACK_TIMEOUT        = 8
) (
   input  logic                                  CLK,
   input  logic                                  RESET,
   input  logic                                  START,
   input  logic                                  BUFFER_BUSY,
   input  logic                                  OUTPUT_STALL,
   output logic [PIXEL_ARRAY_HEIGHT-1:0]         ROW_SELECT,
   output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0] ROW_INDEX,
   output logic                                  SET_BUFFER,
   output logic                                  BUSY,
   output logic                                  FRAME_DONE,
   output logic                                  ERROR
);

   import readout_scheduler_pkg::*;

   localparam int ROW_W   = $clog2(PIXEL_ARRAY_HEIGHT);
   localparam int CNT_MAX = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   readout_state_t   state;
   readout_state_t   next_state;
   logic [ROW_W-1:0] row_index;
   logic             error_q;
   logic             last_row;
   logic             timeout_hit;
   logic             cnt_clear;
   logic             cnt_enable;
   logic [CNT_W-1:0] cnt;

   assign last_row = (row_index == ROW_LAST);

   // One counter serves both the settle and the ack-timeout windows.
   readout_scheduler_counter #(
      .WIDTH (CNT_W)
   ) u_counter (
      .CLK    (CLK),
      .RESET  (RESET),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .count  (cnt)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         row_index <= '0;
         error_q   <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE && START) begin
            row_index <= '0;
            error_q   <= 1'b0;
         end else if (state == NEXT && !last_row && !OUTPUT_STALL) begin
            row_index <= row_index + ROW_W'(1);
         end
         if (timeout_hit) begin
            error_q <= 1'b1;
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      next_state  = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE:     if (START) next_state = SELECT;
         SELECT:   if (cnt == SETTLE_LAST) next_state = LOAD;
         LOAD:     next_state = WAIT_ACK;
         WAIT_ACK: begin
            if (BUFFER_BUSY) begin
               next_state = DRAIN;
            end else if (cnt == TIMEOUT_LAST) begin
               next_state  = IDLE;
               timeout_hit = 1'b1;
            end
         end
         DRAIN:    if (!BUFFER_BUSY) next_state = NEXT;
         NEXT: begin
            if (last_row) begin
               next_state = IDLE;
            end else if (!OUTPUT_STALL) begin
               next_state = SELECT;
            end
         end
         default:  next_state = IDLE;
      endcase
      cnt_clear  = (next_state != state);
      cnt_enable = (state == SELECT) || (state == WAIT_ACK);
   end

   // Outputs decode only from state and registers; ROW_SELECT drops in NEXT for break-before-make.
   always_comb begin
      ROW_SELECT = '0;
      if (state == SELECT || state == LOAD || state == WAIT_ACK || state == DRAIN) begin
         ROW_SELECT = PIXEL_ARRAY_HEIGHT'(1) << row_index;
      end
   end

   assign ROW_INDEX  = row_index;
   assign SET_BUFFER = (state == LOAD);
   assign BUSY       = (state != IDLE);
   assign FRAME_DONE = (state == NEXT) && last_row;
   assign ERROR      = error_q;

endmodule : readout_scheduler

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler (HEIGHT=4, SETTLE=2, ACK_TIMEOUT=8) with a
// simple output-buffer model that raises BUFFER_BUSY one cycle after SET_BUFFER for 3 cycles.
module tb_readout_scheduler;

   logic       CLK;
   logic       RESET;
   logic       START;
   logic       BUFFER_BUSY;
   logic       OUTPUT_STALL;
   logic [3:0] ROW_SELECT;
   logic [1:0] ROW_INDEX;
   logic       SET_BUFFER;
   logic       BUSY;
   logic       FRAME_DONE;
   logic       ERROR;

   int n_cmp = 0;
   int n_bad = 0;
   int busy_left = 0;
   bit model_on = 1'b1;

   readout_scheduler #(
      .PIXEL_ARRAY_HEIGHT (4),
      .SETTLE_CYCLES      (2),
      .ACK_TIMEOUT        (8)
   ) u_dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .START        (START),
      .BUFFER_BUSY  (BUFFER_BUSY),
      .OUTPUT_STALL (OUTPUT_STALL),
      .ROW_SELECT   (ROW_SELECT),
      .ROW_INDEX    (ROW_INDEX),
      .SET_BUFFER   (SET_BUFFER),
      .BUSY         (BUSY),
      .FRAME_DONE   (FRAME_DONE),
      .ERROR        (ERROR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one cycle; outputs are sampled 1 time unit after the edge, then the buffer model reacts.
   task automatic step();
      @(posedge CLK);
      #1;
      BUFFER_BUSY = model_on && (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (SET_BUFFER) busy_left = 3;
   endtask

   task automatic start_frame();
      START = 1'b1;
      step();
      START = 1'b0;
   endtask

   // Unstalled frame: 8 cycles per row, row r in SELECT at 8r, LOAD at 8r+2, NEXT at 8r+7; IDLE from 32.
   function automatic logic [3:0] exp_sel(int t);
      logic [3:0] one;
      one = 4'b0001;
      if (t >= 32 || (t % 8) == 7) return 4'b0000;
      return one << (t / 8);
   endfunction

   task automatic test_reset();
      RESET = 1'b1;
      step();
      step();
      n_cmp++; if (ROW_SELECT !== 4'b0000) begin n_bad++; $display("FAIL reset_row_select got %b exp 0000", ROW_SELECT); end
      n_cmp++; if (SET_BUFFER !== 1'b0) begin n_bad++; $display("FAIL reset_set_buffer got %b exp 0", SET_BUFFER); end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", BUSY); end
      n_cmp++; if (FRAME_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b exp 0", FRAME_DONE); end
      n_cmp++; if (ROW_INDEX !== 2'd0) begin n_bad++; $display("FAIL reset_row_index got %0d exp 0", ROW_INDEX); end
      n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b exp 0", ERROR); end
      RESET = 1'b0;
      step();
      step();
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL idle_without_start busy got %b exp 0", BUSY); end
   endtask

   task automatic test_normal_frame();
      int n_set;
      int n_done;
      n_set  = 0;
      n_done = 0;
      start_frame();
      for (int t = 0; t <= 33; t++) begin
         n_cmp++; if (ROW_SELECT !== exp_sel(t)) begin n_bad++; $display("FAIL normal_row_select t=%0d got %b exp %b", t, ROW_SELECT, exp_sel(t)); end
         n_cmp++; if (SET_BUFFER !== (t < 32 && (t % 8) == 2)) begin n_bad++; $display("FAIL normal_set_buffer t=%0d got %b", t, SET_BUFFER); end
         n_cmp++; if (FRAME_DONE !== (t == 31)) begin n_bad++; $display("FAIL normal_frame_done t=%0d got %b", t, FRAME_DONE); end
         n_cmp++; if (BUSY !== (t < 32)) begin n_bad++; $display("FAIL normal_busy t=%0d got %b", t, BUSY); end
         n_cmp++; if (ROW_INDEX !== ((t < 32) ? 2'(t / 8) : 2'd3)) begin n_bad++; $display("FAIL normal_row_index t=%0d got %0d", t, ROW_INDEX); end
         if (SET_BUFFER === 1'b1) n_set++;
         if (FRAME_DONE === 1'b1) n_done++;
         if (t < 33) step();
      end
      n_cmp++; if (n_set != 4) begin n_bad++; $display("FAIL normal_set_count got %0d exp 4", n_set); end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL normal_done_count got %0d exp 1", n_done); end
      n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL normal_error got %b exp 0", ERROR); end
   endtask

   task automatic test_timeout();
      int n_done;
      n_done   = 0;
      model_on = 1'b0;
      start_frame();
      // LOAD at t=2, WAIT_ACK t=3..10, aborted to IDLE at t=11.
      for (int t = 0; t <= 11; t++) begin
         if (FRAME_DONE === 1'b1) n_done++;
         if (t == 10) begin
            n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL timeout_last_wait busy got %b exp 1", BUSY); end
            n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL timeout_early_error got %b exp 0", ERROR); end
            n_cmp++; if (ROW_SELECT !== 4'b0001) begin n_bad++; $display("FAIL timeout_row_held got %b exp 0001", ROW_SELECT); end
         end
         if (t < 11) step();
      end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL timeout_idle busy got %b exp 0", BUSY); end
      n_cmp++; if (ERROR !== 1'b1) begin n_bad++; $display("FAIL timeout_error got %b exp 1", ERROR); end
      n_cmp++; if (ROW_SELECT !== 4'b0000) begin n_bad++; $display("FAIL timeout_row_select got %b exp 0000", ROW_SELECT); end
      n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL timeout_no_done got %0d exp 0", n_done); end
      repeat (3) step();
      n_cmp++; if (ERROR !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky got %b exp 1", ERROR); end
      busy_left = 0;
      model_on  = 1'b1;
      start_frame();
      n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL timeout_clear_on_start got %b exp 0", ERROR); end
      n_cmp++; if (ROW_SELECT !== 4'b0001) begin n_bad++; $display("FAIL timeout_restart_row got %b exp 0001", ROW_SELECT); end
      n_done = 0;
      repeat (32) begin
         step();
         if (FRAME_DONE === 1'b1) n_done++;
      end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL timeout_recover_done got %0d exp 1", n_done); end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL timeout_recover_idle busy got %b exp 0", BUSY); end
   endtask

   task automatic test_stall();
      int n_done;
      n_done = 0;
      start_frame();
      // Row 1 NEXT at t=15; stall driven for t=15..19 keeps NEXT through t=20; row 2 SELECT at t=21.
      for (int t = 0; t <= 37; t++) begin
         if (t >= 15 && t <= 20) begin
            n_cmp++; if (ROW_SELECT !== 4'b0000) begin n_bad++; $display("FAIL stall_row_select t=%0d got %b exp 0000", t, ROW_SELECT); end
            n_cmp++; if (ROW_INDEX !== 2'd1) begin n_bad++; $display("FAIL stall_row_index t=%0d got %0d exp 1", t, ROW_INDEX); end
         end
         if (t == 21) begin
            n_cmp++; if (ROW_SELECT !== 4'b0100) begin n_bad++; $display("FAIL stall_release_select got %b exp 0100", ROW_SELECT); end
            n_cmp++; if (ROW_INDEX !== 2'd2) begin n_bad++; $display("FAIL stall_release_index got %0d exp 2", ROW_INDEX); end
         end
         if (FRAME_DONE === 1'b1) begin
            n_done++;
            n_cmp++; if (t != 36) begin n_bad++; $display("FAIL stall_done_time got %0d exp 36", t); end
         end
         OUTPUT_STALL = (t >= 15 && t <= 19);
         if (t < 37) step();
      end
      n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL stall_done_count got %0d exp 1", n_done); end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL stall_end_busy got %b exp 0", BUSY); end
   endtask

   task automatic test_start_while_busy();
      int n_set;
      n_set = 0;
      start_frame();
      for (int t = 0; t <= 32; t++) begin
         n_cmp++; if (ROW_SELECT !== exp_sel(t)) begin n_bad++; $display("FAIL busy_start_row_select t=%0d got %b exp %b", t, ROW_SELECT, exp_sel(t)); end
         n_cmp++; if (ROW_INDEX !== ((t < 32) ? 2'(t / 8) : 2'd3)) begin n_bad++; $display("FAIL busy_start_row_index t=%0d got %0d", t, ROW_INDEX); end
         if (SET_BUFFER === 1'b1) n_set++;
         START = (t == 9);
         if (t < 32) step();
      end
      START = 1'b0;
      n_cmp++; if (n_set != 4) begin n_bad++; $display("FAIL busy_start_set_count got %0d exp 4", n_set); end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL busy_start_end busy got %b exp 0", BUSY); end
   endtask

   task automatic test_last_row_stall();
      start_frame();
      for (int t = 0; t <= 32; t++) begin
         if (t == 31) begin
            n_cmp++; if (FRAME_DONE !== 1'b1) begin n_bad++; $display("FAIL last_stall_done got %b exp 1", FRAME_DONE); end
         end
         if (t == 32) begin
            n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL last_stall_idle busy got %b exp 0", BUSY); end
            n_cmp++; if (FRAME_DONE !== 1'b0) begin n_bad++; $display("FAIL last_stall_done_pulse got %b exp 0", FRAME_DONE); end
         end
         OUTPUT_STALL = (t >= 24);
         if (t < 32) step();
      end
      OUTPUT_STALL = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      start_frame();
      repeat (20) step();
      // t=20 is the first DRAIN cycle of row 2.
      n_cmp++; if (ROW_SELECT !== 4'b0100) begin n_bad++; $display("FAIL mid_drain_pre_select got %b exp 0100", ROW_SELECT); end
      RESET = 1'b1;
      step();
      n_cmp++; if (ROW_SELECT !== 4'b0000) begin n_bad++; $display("FAIL mid_drain_row_select got %b exp 0000", ROW_SELECT); end
      n_cmp++; if (SET_BUFFER !== 1'b0) begin n_bad++; $display("FAIL mid_drain_set_buffer got %b exp 0", SET_BUFFER); end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL mid_drain_busy got %b exp 0", BUSY); end
      n_cmp++; if (ROW_INDEX !== 2'd0) begin n_bad++; $display("FAIL mid_drain_row_index got %0d exp 0", ROW_INDEX); end
      n_cmp++; if (ERROR !== 1'b0) begin n_bad++; $display("FAIL mid_drain_error got %b exp 0", ERROR); end
      RESET       = 1'b0;
      busy_left   = 0;
      BUFFER_BUSY = 1'b0;
      step();
      step();
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL mid_drain_stays_idle busy got %b exp 0", BUSY); end
      // A fresh frame after the abort must start its settle count from zero.
      start_frame();
      step();
      step();
      n_cmp++; if (SET_BUFFER !== 1'b1) begin n_bad++; $display("FAIL post_reset_load got %b exp 1", SET_BUFFER); end
      repeat (32) step();
   endtask

   initial begin
      RESET        = 1'b1;
      START        = 1'b0;
      BUFFER_BUSY  = 1'b0;
      OUTPUT_STALL = 1'b0;
      test_reset();
      test_normal_frame();
      test_timeout();
      test_stall();
      test_start_while_busy();
      test_last_row_stall();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule : tb_readout_scheduler
